leitor_teclado_matriz: RTL and testbench

Scans a passive key matrix (columns driven, rows read) and reports one debounced key code per press. It is the input counterpart of the LED-matrix column driver: same scan-clock domain (the divided ~381 Hz clock), the same column-strobe principle, but reading instead of lighting. Output feeds game-selection and control logic in place of discrete debounced buttons.

---
 rtl/teclado_pkg.sv | 23 ++
 rtl/sincronizador_linhas.sv | 24 ++
 rtl/leitor_teclado_matriz.sv | 224 ++++++++++++++++++++++
 tb/tb_leitor_teclado_matriz.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - shared FSM states, default parameters and code-width helper for the keypad reader
package teclado_pkg;

    typedef enum logic [1:0] {
        VARRER   = 2'd0,
        AMOSTRAR = 2'd1,
        AVALIAR  = 2'd2
    } estado_t;

    localparam int NUM_COLUNAS_PADRAO          = 4;
    localparam int NUM_LINHAS_PADRAO           = 4;
    localparam int CICLOS_ESTAB_PADRAO         = 2;
    localparam int VARREDURAS_DEBOUNCE_PADRAO  = 3;
    localparam int VARREDURAS_REPETICAO_PADRAO = 16;

    // Width of a key code; never narrower than one bit.
    function automatic int largura_codigo(input int colunas, input int linhas);
        int posicoes;
        posicoes = colunas * linhas;
        return (posicoes > 2) ? $clog2(posicoes) : 1;
    endfunction

endpackage

// File: rtl/sincronizador_linhas.sv
// rtl/sincronizador_linhas.sv - two-flop synchronizer for the asynchronous, active-low keypad rows
module sincronizador_linhas #(
    parameter int NUM_LINHAS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_LINHAS-1:0] linhas_assinc,
    output logic [NUM_LINHAS-1:0] linhas_sinc
);

    logic [NUM_LINHAS-1:0] meta_q;

    // Reset to the idle (pulled-up) level so no phantom key appears after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q      <= '1;
            linhas_sinc <= '1;
        end else begin
            meta_q      <= linhas_assinc;
            linhas_sinc <= meta_q;
        end
    end

endmodule

// File: rtl/leitor_teclado_matriz.sv
// rtl/leitor_teclado_matriz.sv - debounced matrix keypad scanner; optional auto-repeat under TECLADO_REPETICAO_EN
module leitor_teclado_matriz
    import teclado_pkg::*;
#(
    parameter int NUM_COLUNAS          = NUM_COLUNAS_PADRAO,
    parameter int NUM_LINHAS           = NUM_LINHAS_PADRAO,
    parameter int CICLOS_ESTAB         = CICLOS_ESTAB_PADRAO,
    parameter int VARREDURAS_DEBOUNCE  = VARREDURAS_DEBOUNCE_PADRAO,
    parameter int VARREDURAS_REPETICAO = VARREDURAS_REPETICAO_PADRAO,
    localparam int LARG_COD            = largura_codigo(NUM_COLUNAS, NUM_LINHAS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_LINHAS-1:0]  linhas_teclado,
    output logic [NUM_COLUNAS-1:0] colunas_teclado,
    output logic [LARG_COD-1:0]    codigo_tecla,
    output logic                   tecla_valida,
    output logic                   tecla_pressionada
);

    localparam int LARG_COL   = $clog2(NUM_COLUNAS);
    localparam int LARG_ESTAB = $clog2(CICLOS_ESTAB);
    localparam int LARG_DEB   = $clog2(VARREDURAS_DEBOUNCE + 1);

    localparam logic [LARG_COL-1:0]   ULTIMA_COL   = LARG_COL'(NUM_COLUNAS - 1);
    localparam logic [LARG_ESTAB-1:0] ULTIMO_ESTAB = LARG_ESTAB'(CICLOS_ESTAB - 1);
    localparam logic [LARG_DEB-1:0]   LIMIAR_DEB   = LARG_DEB'(VARREDURAS_DEBOUNCE);

    logic [NUM_LINHAS-1:0] linhas_sinc;

    estado_t               estado_q, estado_d;
    logic [LARG_COL-1:0]   coluna_q, coluna_d;
    logic [LARG_ESTAB-1:0] estab_q, estab_d;

    logic [1:0]            scan_qtd_q, qtd_nova;
    logic [LARG_COD-1:0]   scan_cod_q, cod_novo;

    logic [LARG_DEB-1:0]   cont_press_q, cont_press_d;
    logic [LARG_DEB-1:0]   cont_rel_q, cont_rel_d;
    logic [LARG_COD-1:0]   candidato_q, candidato_d;
    logic [LARG_COD-1:0]   codigo_d;
    logic                  pressionada_d;
    logic                  valida_d;

`ifdef TECLADO_REPETICAO_EN
    localparam int LARG_REP = $clog2(VARREDURAS_REPETICAO + 1);
    localparam logic [LARG_REP-1:0] ULTIMA_REP = LARG_REP'(VARREDURAS_REPETICAO - 1);

    logic [LARG_REP-1:0] cont_rep_q, cont_rep_d;
    logic                rep_ativo_q, rep_ativo_d;
`else
    logic unused_repeticao;
    assign unused_repeticao = |VARREDURAS_REPETICAO;
`endif

    sincronizador_linhas #(
        .NUM_LINHAS (NUM_LINHAS)
    ) u_sincronizador (
        .clock         (clock),
        .reset         (reset),
        .linhas_assinc (linhas_teclado),
        .linhas_sinc   (linhas_sinc)
    );

    // Strobe is gated by reset so the columns sit idle while reset is held.
    always_comb begin
        estado_d        = estado_q;
        coluna_d        = coluna_q;
        estab_d         = estab_q;
        colunas_teclado = '1;
        if (!reset && estado_q != AVALIAR) begin
            colunas_teclado[coluna_q] = 1'b0;
        end
        case (estado_q)
            VARRER: begin
                if (estab_q == ULTIMO_ESTAB) begin
                    estab_d  = '0;
                    estado_d = AMOSTRAR;
                end else begin
                    estab_d = estab_q + 1'b1;
                end
            end
            AMOSTRAR: begin
                if (coluna_q == ULTIMA_COL) begin
                    coluna_d = '0;
                    estado_d = AVALIAR;
                end else begin
                    coluna_d = coluna_q + 1'b1;
                    estado_d = VARRER;
                end
            end
            default: begin
                estado_d = VARRER;
            end
        endcase
    end

    // Fold this column's rows into the running scan tally (count saturates at 2).
    always_comb begin
        qtd_nova = scan_qtd_q;
        cod_novo = scan_cod_q;
        for (int r = 0; r < NUM_LINHAS; r++) begin
            if (!linhas_sinc[r]) begin
                if (qtd_nova != 2'd2) begin
                    qtd_nova = qtd_nova + 2'd1;
                end
                cod_novo = LARG_COD'(r * NUM_COLUNAS) + LARG_COD'(coluna_q);
            end
        end
    end

    always_comb begin
        cont_press_d  = cont_press_q;
        cont_rel_d    = cont_rel_q;
        candidato_d   = candidato_q;
        codigo_d      = codigo_tecla;
        pressionada_d = tecla_pressionada;
        valida_d      = 1'b0;
`ifdef TECLADO_REPETICAO_EN
        cont_rep_d    = cont_rep_q;
        rep_ativo_d   = rep_ativo_q;
`endif
        if (estado_q == AVALIAR) begin
            case (scan_qtd_q)
                2'd1: begin
                    cont_rel_d = '0;
                    if (cont_press_q != '0 && scan_cod_q == candidato_q) begin
                        if (cont_press_q != LIMIAR_DEB) begin
                            cont_press_d = cont_press_q + 1'b1;
                        end
                    end else begin
                        cont_press_d = LARG_DEB'(1);
                        candidato_d  = scan_cod_q;
                    end
                    if (cont_press_d == LIMIAR_DEB && !tecla_pressionada) begin
                        codigo_d      = scan_cod_q;
                        valida_d      = 1'b1;
                        pressionada_d = 1'b1;
`ifdef TECLADO_REPETICAO_EN
                        cont_rep_d    = '0;
                        rep_ativo_d   = 1'b1;
                    end else if (rep_ativo_q && tecla_pressionada &&
                                 scan_cod_q == codigo_tecla) begin
                        if (cont_rep_q == ULTIMA_REP) begin
                            cont_rep_d = '0;
                            valida_d   = 1'b1;
                        end else begin
                            cont_rep_d = cont_rep_q + 1'b1;
                        end
                    end else begin
                        rep_ativo_d = 1'b0;
`endif
                    end
                end
                2'd0: begin
                    cont_press_d = '0;
                    if (cont_rel_q != LIMIAR_DEB) begin
                        cont_rel_d = cont_rel_q + 1'b1;
                    end
                    if (cont_rel_d == LIMIAR_DEB) begin
                        pressionada_d = 1'b0;
                    end
`ifdef TECLADO_REPETICAO_EN
                    rep_ativo_d = 1'b0;
`endif
                end
                default: begin
                    // Ghosting: position is ambiguous, so restart both debouncers.
                    cont_press_d = '0;
                    cont_rel_d   = '0;
`ifdef TECLADO_REPETICAO_EN
                    rep_ativo_d  = 1'b0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q          <= VARRER;
            coluna_q          <= '0;
            estab_q           <= '0;
            scan_qtd_q        <= '0;
            scan_cod_q        <= '0;
            cont_press_q      <= '0;
            cont_rel_q        <= '0;
            candidato_q       <= '0;
            codigo_tecla      <= '0;
            tecla_valida      <= 1'b0;
            tecla_pressionada <= 1'b0;
        end else begin
            estado_q          <= estado_d;
            coluna_q          <= coluna_d;
            estab_q           <= estab_d;
            cont_press_q      <= cont_press_d;
            cont_rel_q        <= cont_rel_d;
            candidato_q       <= candidato_d;
            codigo_tecla      <= codigo_d;
            tecla_valida      <= valida_d;
            tecla_pressionada <= pressionada_d;
            if (estado_q == AMOSTRAR) begin
                scan_qtd_q <= qtd_nova;
                scan_cod_q <= cod_novo;
            end else if (estado_q == AVALIAR) begin
                scan_qtd_q <= '0;
                scan_cod_q <= '0;
            end
        end
    end

`ifdef TECLADO_REPETICAO_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_rep_q  <= '0;
            rep_ativo_q <= 1'b0;
        end else begin
            cont_rep_q  <= cont_rep_d;
            rep_ativo_q <= rep_ativo_d;
        end
    end
`endif

endmodule

// File: tb/tb_leitor_teclado_matriz.sv
// tb/tb_leitor_teclado_matriz.sv - self-checking bench for leitor_teclado_matriz
module tb_leitor_teclado_matriz;

    localparam int PERIODO = 13;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  linhas_teclado;
    logic [3:0]  colunas_teclado;
    logic [3:0]  codigo_tecla;
    logic        tecla_valida;
    logic        tecla_pressionada;
    logic [15:0] teclas;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] teclas;
        logic        valida;
        logic        press;
        logic [3:0]  codigo;
    } vetor_t;

    vetor_t tabela[$];

    always #5 clock = ~clock;

    leitor_teclado_matriz dut (
        .clock             (clock),
        .reset             (reset),
        .linhas_teclado    (linhas_teclado),
        .colunas_teclado   (colunas_teclado),
        .codigo_tecla      (codigo_tecla),
        .tecla_valida      (tecla_valida),
        .tecla_pressionada (tecla_pressionada)
    );

    // Passive matrix: a held key shorts its row to its column when that column is low.
    always_comb begin
        linhas_teclado = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (teclas[r*4+c] && !colunas_teclado[c]) linhas_teclado[r] = 1'b0;
            end
        end
    end

    function automatic logic [15:0] k(input int n);
        logic [15:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic check(input string nome, input int atual, input int esperado);
        n_cmp++;
        if (atual != esperado) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic add(input logic [15:0] t, input int n, input logic v, input logic p,
                       input logic [3:0] c);
        vetor_t e;
        e.teclas = t;
        e.valida = v;
        e.press  = p;
        e.codigo = c;
        for (int i = 0; i < n; i++) tabela.push_back(e);
    endtask

    task automatic liberar_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic varredura();
        repeat (PERIODO) @(negedge clock);
    endtask

    function automatic logic [3:0] coluna_esperada(input int ciclo);
        int fase;
        logic [3:0] v;
        fase = ciclo % PERIODO;
        v = 4'b1111;
        if (fase < 12) v[fase/3] = 1'b0;
        return v;
    endfunction

    initial begin
        int pulsos[$];
        int esperado_pulsos[$];

        teclas = '0;
        reset  = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_colunas", colunas_teclado, 4'b1111);
        check("reset_codigo", codigo_tecla, 0);
        check("reset_valida", tecla_valida, 0);
        check("reset_press", tecla_pressionada, 0);
        reset = 1'b0;
        #1;
        for (int ciclo = 0; ciclo < 2 * PERIODO; ciclo++) begin
            check($sformatf("colunas_ciclo%0d", ciclo), colunas_teclado, coluna_esperada(ciclo));
            @(negedge clock);
        end

        // One entry per scan: keys held during it, outputs expected right after it.
        add(16'h0000,      1, 0, 0, 0);
        add(k(6),          2, 0, 0, 0);
        add(k(6),          1, 1, 1, 6);
        add(k(6),          2, 0, 1, 6);
        add(16'h0000,      2, 0, 1, 6);
        add(16'h0000,      1, 0, 0, 6);
        add(k(3),          1, 0, 0, 6);
        add(16'h0000,      1, 0, 0, 6);
        add(k(3),          1, 0, 0, 6);
        add(16'h0000,      1, 0, 0, 6);
        add(k(3),          2, 0, 0, 6);
        add(k(3),          1, 1, 1, 3);
        add(16'h0000,      2, 0, 1, 3);
        add(16'h0000,      1, 0, 0, 3);
        add(k(1) | k(9),   3, 0, 0, 3);
        add(k(1),          2, 0, 0, 3);
        add(k(1),          1, 1, 1, 1);
        add(k(1) | k(9),   1, 0, 1, 1);
        add(k(1),          1, 0, 1, 1);
        add(16'h0000,      2, 0, 1, 1);
        add(16'h0000,      1, 0, 0, 1);
        add(k(9),          2, 0, 0, 1);
        add(k(9),          1, 1, 1, 9);
        add(k(9),          1, 0, 1, 9);
        add(16'h0000,      2, 0, 1, 9);
        add(16'h0000,      1, 0, 0, 9);
        add(k(9),          2, 0, 0, 9);
        add(k(9),          1, 1, 1, 9);
        add(k(15),         3, 0, 1, 9);
        add(16'h0000,      2, 0, 1, 9);
        add(16'h0000,      1, 0, 0, 9);

        liberar_reset();
        for (int i = 0; i < tabela.size(); i++) begin
            teclas = tabela[i].teclas;
            varredura();
            check($sformatf("scan%0d_valida", i + 1), tecla_valida, tabela[i].valida);
            check($sformatf("scan%0d_press", i + 1), tecla_pressionada, tabela[i].press);
            check($sformatf("scan%0d_codigo", i + 1), codigo_tecla, tabela[i].codigo);
        end

        // Reset in the middle of a hold, key still down afterwards.
        teclas = k(9);
        varredura();
        varredura();
        check("hold_pre_press", tecla_pressionada, 0);
        varredura();
        check("hold_valida", tecla_valida, 1);
        check("hold_codigo", codigo_tecla, 9);
        @(negedge clock);
        check("hold_pulso_unico", tecla_valida, 0);
        check("hold_press", tecla_pressionada, 1);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("midreset_codigo", codigo_tecla, 0);
        check("midreset_press", tecla_pressionada, 0);
        check("midreset_valida", tecla_valida, 0);
        check("midreset_colunas", colunas_teclado, 4'b1111);
        reset = 1'b0;
        #1;
        check("midreset_col0", colunas_teclado, 4'b1110);
        varredura();
        varredura();
        check("repress_cedo_valida", tecla_valida, 0);
        check("repress_cedo_press", tecla_pressionada, 0);
        varredura();
        check("repress_valida", tecla_valida, 1);
        check("repress_codigo", codigo_tecla, 9);
        check("repress_press", tecla_pressionada, 1);

        // Long hold of key 5: repeat pulses only when the feature is built in.
        teclas = '0;
        liberar_reset();
        teclas = k(5);
        for (int s = 1; s <= 40; s++) begin
            varredura();
            if (tecla_valida) begin
                pulsos.push_back(s);
                check($sformatf("repet_codigo_s%0d", s), codigo_tecla, 5);
            end
        end
`ifdef TECLADO_REPETICAO_EN
        esperado_pulsos = '{3, 19, 35};
`else
        esperado_pulsos = '{3};
`endif
        check("repet_qtd_pulsos", pulsos.size(), esperado_pulsos.size());
        for (int i = 0; i < esperado_pulsos.size(); i++) begin
            check($sformatf("repet_pulso%0d", i), (i < pulsos.size()) ? pulsos[i] : -1,
                  esperado_pulsos[i]);
        end
        check("repet_press_final", tecla_pressionada, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
